peg_l2_rx_hdr_parser: RTL and testbench
=======================================

# peg_l2_rx_hdr_parser

Receive-side L2 framer for the Pegasus MAC. It sits between the RS (RMII) receive byte aggregator and the L2 receive buffer. It strips preamble and SFD (0x55 x7, 0xD5), parses the MAC header into the package `l2_mac_hdr_t` layout, including an optional 802.1Q tag, and forwards payload bytes with SOF/EOF marking.

## Interface
- `PRE_MIN_BYTES`, default 7: minimum count of 0x55 bytes before SFD; legal range 1–7.
- `VLAN_TPID`, default 16'h8100: type value that marks a VLAN-tagged frame.
- `clk_ir` in 1: clock; the only clock domain.
- `rst_ih` in 1: reset, synchronous, active-high.
- `rx_en_ih` in 1: frame envelope from RS; high for the whole frame, including preamble.
- `rx_valid_ih` in 1: byte strobe; ignored while `rx_en_ih`=0.
- `rx_data_id` in 8: received byte.
- `hdr_od` out 144: `l2_mac_hdr_t` {da, sa, len, ptype, vlan_tci}.
- `hdr_valid_oh` out 1: one-cycle pulse; `hdr_od` is valid.
- `pld_valid_oh` out 1: payload byte strobe.
- `pld_data_od` out 8: payload byte.
- `pld_sof_oh` out 1: first payload byte; qualified by `pld_valid_oh`.
- `pld_eof_oh` out 1: last payload byte; qualified by `pld_valid_oh`.
- `err_oh` out 1: one-cycle error pulse.
- `err_code_od` out 2: 1 = preamble/SFD error, 2 = runt (frame ended inside the header); held until the next error.

## Operation
- **FSM states:** IDLE, PRE, DA, SA, TYPE, TCI, LEN, PLD, DROP. Byte counter is 3 bits; preamble counter saturates at 7.
- **IDLE:** on `rx_en_ih` rising, go to PRE and clear the preamble count.
- **PRE:** each 0x55 increments the count. 0xD5 with count ≥ `PRE_MIN_BYTES` goes to DA. 0xD5 with count < min, or any other byte, raises error 1 and goes to DROP.
- **DA, SA:** 6 bytes each, MSB first (first byte lands in da[47:40]).
- **TYPE:** 2 bytes, MSB first.
  - If the value equals `VLAN_TPID`: ptype = value, go to TCI (2 bytes into vlan_tci), then LEN (2 bytes into len).
  - Otherwise: len = value, ptype = 0, vlan_tci = 0.
- **Header complete:** pulse `hdr_valid_oh` and go to PLD. `hdr_od` holds its value until the next frame's DA byte 0.
- **PLD:** uses a one-byte holding register.
  - Each new byte releases the held byte to the output. `pld_sof_oh` is set on the first released byte of the frame.
  - When `rx_en_ih` falls, the held byte is released with `pld_eof_oh`=1. If only one payload byte was received, SOF and EOF are both set on it.
  - Zero-byte payload: no pld strobes are produced.
- **`rx_en_ih` fall in PRE/DA/SA/TYPE/TCI/LEN:** raise error 2 (error 1 if in PRE), suppress `hdr_valid_oh`, go to IDLE.
- **DROP:** discard bytes until `rx_en_ih` falls, then go to IDLE. No further errors are raised for that frame.
- **`rx_en_ih` fall and `rx_valid_ih` in the same cycle:** the byte is ignored, and the fall is processed.
- **Reset (including mid-frame):** state IDLE, holding register empty, all outputs 0 (`hdr_od`=0, `err_code_od`=0, strobes 0). A frame in progress at reset is lost silently, with no EOF and no error.

## Timing
- All outputs are registered.
- `hdr_valid_oh` is asserted the cycle after the last header byte is sampled.
- Payload latency:
  - byte N is output the cycle after byte N+1 is sampled;
  - the last byte is output the cycle after `rx_en_ih` is sampled low.
- `err_oh` is asserted the cycle after the offending byte or `rx_en_ih` edge.
- The block accepts one byte per cycle back-to-back. There is no backpressure; the downstream side must sink every strobe.
- A new frame may begin (`rx_en_ih` high) the cycle after a fall is sampled.

## Test plan
- **Untagged frame:** 7×0x55, 0xD5, DA=01:02:03:04:05:06, SA=0A:0B:0C:0D:0E:0F, type 0x0040, then 64 payload bytes 0x00..0x3F.
  - hdr: len=0x0040, ptype=0, tci=0.
  - 64 pld strobes; SOF on 0x00, EOF on 0x3F, EOF the cycle after `rx_en_ih` falls.
- **Tagged frame:** type 0x8100, TCI 0xA123, len 0x002E.
  - ptype=0x8100, vlan_tci={pcp 5, dei 0, vid 0x123}, len=0x002E.
  - The payload begins with the byte after len.
- **Preamble errors:**
  - `PRE_MIN_BYTES`=7 with 5×0x55 then 0xD5: err_code 1, no hdr_valid, no pld.
  - Preamble containing 0x57: same response.
  - The next good frame parses normally.
- **Runt:** `rx_en_ih` falls after SA byte 3 → err_code 2, no hdr_valid. One-payload-byte frame → single strobe with SOF=EOF=1.
- **Reset mid-payload:** assert `rst_ih` after 10 payload bytes.
  - All outputs are 0 the next cycle, with no EOF.
  - The following frame parses correctly.
- **Gapped strobes:** `rx_valid_ih` at 1/4 duty (RMII rate) → identical hdr and payload byte sequence as the back-to-back case.

Source files
------------

// File: rtl/peg_l2_rx_hdr_parser.sv
// Purpose : RMII receive framer; strips preamble/SFD, parses MAC header (+ optional 802.1Q tag), forwards payload with SOF/EOF.
// Latency : hdr_valid_oh 1 cycle after last header byte; payload byte N 1 cycle after byte N+1 (last byte 1 cycle after rx_en_ih falls).
// Backpressure: none; accepts one byte per cycle, downstream must sink every strobe.
//
// Ports:
//   clk_ir, rst_ih            clock, synchronous active-high reset
//   rx_en_ih / rx_valid_ih /  frame envelope, byte strobe and byte from the RS aggregator
//   rx_data_id
//   hdr_od / hdr_valid_oh     parsed header {da, sa, len, ptype, vlan_tci} and its one-cycle pulse
//   pld_*                     payload byte stream with SOF/EOF flags
//   err_oh / err_code_od      error pulse; code 1 = preamble/SFD, 2 = runt (held until next error)
module peg_l2_rx_hdr_parser #(
    parameter int unsigned PRE_MIN_BYTES = 7,
    parameter logic [15:0] VLAN_TPID     = 16'h8100
) (
    input  logic         clk_ir,
    input  logic         rst_ih,
    input  logic         rx_en_ih,
    input  logic         rx_valid_ih,
    input  logic [7:0]   rx_data_id,
    output logic [143:0] hdr_od,
    output logic         hdr_valid_oh,
    output logic         pld_valid_oh,
    output logic [7:0]   pld_data_od,
    output logic         pld_sof_oh,
    output logic         pld_eof_oh,
    output logic         err_oh,
    output logic [1:0]   err_code_od
);

    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] len;
        logic [15:0] ptype;
        logic [15:0] vlan_tci;
    } l2_mac_hdr_t;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_DA, S_SA, S_TYPE, S_TCI, S_LEN, S_PLD, S_DROP
    } state_t;

    localparam logic [2:0] PRE_MIN  = 3'(PRE_MIN_BYTES);
    localparam logic [1:0] ERR_PRE  = 2'd1;
    localparam logic [1:0] ERR_RUNT = 2'd2;

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic        hold_vld_q, hold_vld_d;
    logic        first_q, first_d;
    l2_mac_hdr_t hdr_q, hdr_d;
    logic        hdr_vld_d, pld_vld_d, sof_d, eof_d, err_d;
    logic [7:0]  pld_dat_d;
    logic [1:0]  err_code_d;

    logic        rx_en_q;
    logic        rise, pre_act, is_pre, sfd_ok, hdr_state;
    logic [2:0]  pre_base;
    logic [15:0] type_val;

    // Deliberately not reset: it follows the envelope through reset, so a frame
    // still in flight when reset releases is not taken for a new rising edge.
    always_ff @(posedge clk_ir) begin
        rx_en_q <= rx_en_ih;
    end

    // A rising edge seen in IDLE is handled exactly like PRE with a zero count,
    // so the first preamble byte may arrive in the same cycle as the edge.
    assign rise      = rx_en_ih & ~rx_en_q;
    assign pre_act   = (state_q == S_PRE) | ((state_q == S_IDLE) & rise);
    assign pre_base  = (state_q == S_PRE) ? pcnt_q : 3'd0;
    assign is_pre    = (rx_data_id == 8'h55);
    assign sfd_ok    = (rx_data_id == 8'hD5) && (pre_base >= PRE_MIN);
    assign hdr_state = state_q inside {S_DA, S_SA, S_TYPE, S_TCI, S_LEN};
    assign type_val  = {type_hi_q, rx_data_id};

    // State register
    always_ff @(posedge clk_ir) begin
        if (rst_ih) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an envelope fall always wins over a same-cycle byte.
    always_comb begin
        state_d = state_q;
        if (pre_act) begin
            if (!rx_en_ih)        state_d = S_IDLE;
            else if (rx_valid_ih) begin
                if (is_pre)       state_d = S_PRE;
                else if (sfd_ok)  state_d = S_DA;
                else              state_d = S_DROP;
            end else              state_d = S_PRE;
        end else begin
            case (state_q)
                S_DA:   if (!rx_en_ih) state_d = S_IDLE;
                        else if (rx_valid_ih && bcnt_q == 3'd5) state_d = S_SA;
                S_SA:   if (!rx_en_ih) state_d = S_IDLE;
                        else if (rx_valid_ih && bcnt_q == 3'd5) state_d = S_TYPE;
                S_TYPE: if (!rx_en_ih) state_d = S_IDLE;
                        else if (rx_valid_ih && bcnt_q == 3'd1)
                            state_d = (type_val == VLAN_TPID) ? S_TCI : S_PLD;
                S_TCI:  if (!rx_en_ih) state_d = S_IDLE;
                        else if (rx_valid_ih && bcnt_q == 3'd1) state_d = S_LEN;
                S_LEN:  if (!rx_en_ih) state_d = S_IDLE;
                        else if (rx_valid_ih && bcnt_q == 3'd1) state_d = S_PLD;
                S_PLD, S_DROP: if (!rx_en_ih) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath / next output values
    always_comb begin
        bcnt_d     = bcnt_q;
        pcnt_d     = pcnt_q;
        type_hi_d  = type_hi_q;
        hold_dat_d = hold_dat_q;
        hold_vld_d = hold_vld_q;
        first_d    = first_q;
        hdr_d      = hdr_q;
        hdr_vld_d  = 1'b0;
        pld_vld_d  = 1'b0;
        pld_dat_d  = pld_data_od;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_od;

        if (state_d != state_q)              bcnt_d = 3'd0;
        else if (hdr_state && rx_en_ih && rx_valid_ih) bcnt_d = bcnt_q + 3'd1;

        if (pre_act) begin
            pcnt_d = pre_base;
            if (!rx_en_ih) begin
                err_d      = 1'b1;
                err_code_d = ERR_PRE;
            end else if (rx_valid_ih) begin
                if (is_pre) begin
                    if (pre_base != 3'd7) pcnt_d = pre_base + 3'd1;
                end else if (!sfd_ok) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_PRE;
                end
            end
        end else if (hdr_state && !rx_en_ih) begin
            err_d      = 1'b1;
            err_code_d = ERR_RUNT;
        end else if (rx_en_ih && rx_valid_ih) begin
            // Header fields are shifted in MSB first; the whole header is cleared
            // on DA byte 0 so untagged frames end with ptype/vlan_tci = 0.
            case (state_q)
                S_DA: begin
                    if (bcnt_q == 3'd0) hdr_d = '0;
                    hdr_d.da = {hdr_d.da[39:0], rx_data_id};
                end
                S_SA:  hdr_d.sa = {hdr_q.sa[39:0], rx_data_id};
                S_TYPE: begin
                    if (bcnt_q == 3'd0) type_hi_d = rx_data_id;
                    else if (type_val == VLAN_TPID) hdr_d.ptype = type_val;
                    else begin
                        hdr_d.len      = type_val;
                        hdr_d.ptype    = '0;
                        hdr_d.vlan_tci = '0;
                        hdr_vld_d      = 1'b1;
                        first_d        = 1'b1;
                        hold_vld_d     = 1'b0;
                    end
                end
                S_TCI: hdr_d.vlan_tci = {hdr_q.vlan_tci[7:0], rx_data_id};
                S_LEN: begin
                    hdr_d.len = {hdr_q.len[7:0], rx_data_id};
                    if (bcnt_q == 3'd1) begin
                        hdr_vld_d  = 1'b1;
                        first_d    = 1'b1;
                        hold_vld_d = 1'b0;
                    end
                end
                S_PLD: begin
                    // One-byte holding register: a byte is only released once we
                    // know whether it is the last one.
                    if (hold_vld_q) begin
                        pld_vld_d = 1'b1;
                        pld_dat_d = hold_dat_q;
                        sof_d     = first_q;
                        first_d   = 1'b0;
                    end
                    hold_dat_d = rx_data_id;
                    hold_vld_d = 1'b1;
                end
                default: ;
            endcase
        end else if (state_q == S_PLD && !rx_en_ih) begin
            if (hold_vld_q) begin
                pld_vld_d = 1'b1;
                pld_dat_d = hold_dat_q;
                sof_d     = first_q;
                eof_d     = 1'b1;
            end
            hold_vld_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            bcnt_q       <= '0;
            pcnt_q       <= '0;
            type_hi_q    <= '0;
            hold_dat_q   <= '0;
            hold_vld_q   <= 1'b0;
            first_q      <= 1'b0;
            hdr_q        <= '0;
            hdr_valid_oh <= 1'b0;
            pld_valid_oh <= 1'b0;
            pld_data_od  <= '0;
            pld_sof_oh   <= 1'b0;
            pld_eof_oh   <= 1'b0;
            err_oh       <= 1'b0;
            err_code_od  <= '0;
        end else begin
            bcnt_q       <= bcnt_d;
            pcnt_q       <= pcnt_d;
            type_hi_q    <= type_hi_d;
            hold_dat_q   <= hold_dat_d;
            hold_vld_q   <= hold_vld_d;
            first_q      <= first_d;
            hdr_q        <= hdr_d;
            hdr_valid_oh <= hdr_vld_d;
            pld_valid_oh <= pld_vld_d;
            pld_data_od  <= pld_dat_d;
            pld_sof_oh   <= sof_d;
            pld_eof_oh   <= eof_d;
            err_oh       <= err_d;
            err_code_od  <= err_code_d;
        end
    end

    assign hdr_od = hdr_q;

endmodule

// File: tb/tb_peg_l2_rx_hdr_parser.sv
// Testbench for peg_l2_rx_hdr_parser: directed frames from the test plan plus
// randomized frames; expectations come from a whole-frame reference model and
// are checked by an independent monitor popping per-stream queues.
module tb_peg_l2_rx_hdr_parser;

    localparam int unsigned PRE_MIN = 7;
    localparam logic [15:0] TPID    = 16'h8100;

    logic         clk_ir = 1'b0;
    logic         rst_ih;
    logic         rx_en_ih;
    logic         rx_valid_ih;
    logic [7:0]   rx_data_id;
    logic [143:0] hdr_od;
    logic         hdr_valid_oh;
    logic         pld_valid_oh;
    logic [7:0]   pld_data_od;
    logic         pld_sof_oh;
    logic         pld_eof_oh;
    logic         err_oh;
    logic [1:0]   err_code_od;

    always #5 clk_ir = ~clk_ir;

    peg_l2_rx_hdr_parser #(
        .PRE_MIN_BYTES (PRE_MIN),
        .VLAN_TPID     (TPID)
    ) dut (
        .clk_ir       (clk_ir),
        .rst_ih       (rst_ih),
        .rx_en_ih     (rx_en_ih),
        .rx_valid_ih  (rx_valid_ih),
        .rx_data_id   (rx_data_id),
        .hdr_od       (hdr_od),
        .hdr_valid_oh (hdr_valid_oh),
        .pld_valid_oh (pld_valid_oh),
        .pld_data_od  (pld_data_od),
        .pld_sof_oh   (pld_sof_oh),
        .pld_eof_oh   (pld_eof_oh),
        .err_oh       (err_oh),
        .err_code_od  (err_code_od)
    );

    int           tests = 0;
    int           fails = 0;
    logic [143:0] exp_hdr[$];
    logic [9:0]   exp_pld[$];   // {data, sof, eof}
    logic [1:0]   exp_err[$];
    logic [1:0]   last_err = 2'd0;
    logic [7:0]   frm[$];
    logic [7:0]   base_frm[$];

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic unexpected(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got a strobe, expected none", nm);
    endtask

    task automatic cyc();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic push_pre(input int n);
        repeat (n) frm.push_back(8'h55);
    endtask

    // Reference model: decides the outcome of a whole frame from its byte list.
    function automatic void model();
        int           i;
        int           n55;
        int           ps;
        logic [7:0]   hb[$];
        logic [143:0] h;
        logic [15:0]  typ;
        i   = 0;
        n55 = 0;
        while (i < frm.size() && frm[i] == 8'h55) begin
            n55++;
            i++;
        end
        if (i >= frm.size() || frm[i] != 8'hD5 || n55 < int'(PRE_MIN)) begin
            exp_err.push_back(2'd1);
            last_err = 2'd1;
            return;
        end
        for (int k = i + 1; k < frm.size(); k++) hb.push_back(frm[k]);
        if (hb.size() < 14) begin
            exp_err.push_back(2'd2);
            last_err = 2'd2;
            return;
        end
        h = '0;
        for (int k = 0; k < 6; k++) begin
            h[143 - 8*k -: 8] = hb[k];
            h[95 - 8*k -: 8]  = hb[6 + k];
        end
        typ = {hb[12], hb[13]};
        if (typ == TPID) begin
            if (hb.size() < 18) begin
                exp_err.push_back(2'd2);
                last_err = 2'd2;
                return;
            end
            h[31:16] = typ;
            h[15:0]  = {hb[14], hb[15]};
            h[47:32] = {hb[16], hb[17]};
            ps = 18;
        end else begin
            h[47:32] = typ;
            ps = 14;
        end
        exp_hdr.push_back(h);
        for (int k = ps; k < hb.size(); k++)
            exp_pld.push_back({hb[k], k == ps, k == hb.size() - 1});
    endfunction

    // gap_mode: 0 back-to-back, 1 one byte every 4 cycles, 2 random gaps
    task automatic send_frame(input int gap_mode, input bit junk_fall);
        int gaps;
        model();
        rx_en_ih    = 1'b1;
        rx_valid_ih = 1'b0;
        if ($urandom_range(1, 0) == 1) cyc();
        foreach (frm[k]) begin
            rx_valid_ih = 1'b1;
            rx_data_id  = frm[k];
            cyc();
            rx_valid_ih = 1'b0;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(3, 0));
            repeat (gaps) cyc();
        end
        rx_en_ih    = 1'b0;
        rx_valid_ih = junk_fall;
        rx_data_id  = 8'($urandom);
        cyc();
        rx_valid_ih = 1'b0;
    endtask

    task automatic build_rand();
        int          fault;
        int          npre;
        int          n;
        logic [15:0] typ;
        frm.delete();
        fault = int'($urandom_range(5, 0));
        npre  = (fault == 3) ? int'($urandom_range(6, 1)) : int'($urandom_range(9, 7));
        push_pre(npre);
        if (fault == 4) frm[$urandom_range(npre - 1, 0)] = 8'($urandom);
        frm.push_back(8'hD5);
        repeat (12) frm.push_back(8'($urandom));
        if ($urandom_range(1, 0) == 1) begin
            frm.push_back(8'h81);
            frm.push_back(8'h00);
            repeat (4) frm.push_back(8'($urandom));
        end else begin
            typ = 16'($urandom_range(16'h7fff, 0));
            frm.push_back(typ[15:8]);
            frm.push_back(typ[7:0]);
        end
        n = int'($urandom_range(40, 0));
        repeat (n) frm.push_back(8'($urandom));
        if (fault == 5) begin
            n   = int'($urandom_range(frm.size() - 1, 1));
            frm = frm[0:n-1];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hdr"},      hdr_od,                0);
        chk({tag, "_hdr_vld"},  144'(hdr_valid_oh),    0);
        chk({tag, "_pld_vld"},  144'(pld_valid_oh),    0);
        chk({tag, "_pld_dat"},  144'(pld_data_od),     0);
        chk({tag, "_sof"},      144'(pld_sof_oh),      0);
        chk({tag, "_eof"},      144'(pld_eof_oh),      0);
        chk({tag, "_err"},      144'(err_oh),          0);
        chk({tag, "_err_code"}, 144'(err_code_od),     0);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk_ir);
            if (hdr_valid_oh) begin
                if (exp_hdr.size() == 0) unexpected("hdr");
                else chk("hdr", hdr_od, exp_hdr.pop_front());
            end
            if (pld_valid_oh) begin
                if (exp_pld.size() == 0) unexpected("pld");
                else chk("pld", 144'({pld_data_od, pld_sof_oh, pld_eof_oh}), 144'(exp_pld.pop_front()));
            end
            if (err_oh) begin
                if (exp_err.size() == 0) unexpected("err");
                else chk("err_code", 144'(err_code_od), 144'(exp_err.pop_front()));
            end
        end
    end

    initial begin
        rst_ih      = 1'b1;
        rx_en_ih    = 1'b0;
        rx_valid_ih = 1'b0;
        rx_data_id  = 8'h00;
        repeat (3) cyc();
        @(negedge clk_ir);
        chk_all_zero("reset");
        rst_ih = 1'b0;
        cyc();
        cyc();

        // Untagged frame, back-to-back
        frm.delete();
        push_pre(7);
        frm.push_back(8'hD5);
        for (int k = 1; k <= 6; k++) frm.push_back(8'(k));
        for (int k = 10; k <= 15; k++) frm.push_back(8'(k));
        frm.push_back(8'h00);
        frm.push_back(8'h40);
        for (int k = 0; k < 64; k++) frm.push_back(8'(k));
        base_frm = frm;
        send_frame(0, 1'b0);
        @(negedge clk_ir);
        chk("eof_timing", 144'({pld_valid_oh, pld_eof_oh, pld_data_od}), 144'({2'b11, 8'h3F}));

        // Tagged frame
        frm.delete();
        push_pre(7);
        frm.push_back(8'hD5);
        repeat (12) frm.push_back(8'($urandom));
        frm.push_back(8'h81); frm.push_back(8'h00);
        frm.push_back(8'hA1); frm.push_back(8'h23);
        frm.push_back(8'h00); frm.push_back(8'h2E);
        for (int k = 0; k < 46; k++) frm.push_back(8'(8'hC0 + k));
        send_frame(0, 1'b0);

        // Short preamble, then a bad preamble byte, then a good frame
        frm.delete();
        push_pre(5);
        frm.push_back(8'hD5);
        repeat (20) frm.push_back(8'($urandom));
        send_frame(0, 1'b0);
        frm.delete();
        push_pre(2);
        frm.push_back(8'h57);
        push_pre(4);
        frm.push_back(8'hD5);
        repeat (20) frm.push_back(8'($urandom));
        send_frame(0, 1'b1);
        frm = base_frm;
        send_frame(0, 1'b0);

        // Runt after SA byte 3, then a one-payload-byte frame
        frm = base_frm[0:17];
        send_frame(0, 1'b0);
        frm = base_frm[0:22];
        send_frame(0, 1'b0);

        // Reset after 10 payload bytes: 9 released, no EOF, then silence
        frm.delete();
        push_pre(7);
        frm.push_back(8'hD5);
        repeat (12) frm.push_back(8'($urandom));
        frm.push_back(8'h00);
        frm.push_back(8'h14);
        for (int k = 0; k < 10; k++) frm.push_back(8'(8'h80 + k));
        model();
        exp_pld.pop_back();
        rx_en_ih = 1'b1;
        foreach (frm[k]) begin
            rx_valid_ih = 1'b1;
            rx_data_id  = frm[k];
            cyc();
        end
        rst_ih     = 1'b1;
        rx_data_id = 8'h8A;
        cyc();
        @(negedge clk_ir);
        chk_all_zero("midrst");
        rst_ih     = 1'b0;
        rx_data_id = 8'h8B;
        cyc();
        rx_data_id = 8'h8C;
        cyc();
        rx_en_ih    = 1'b0;
        rx_valid_ih = 1'b0;
        cyc();
        last_err = 2'd0;
        frm = base_frm;
        send_frame(0, 1'b0);

        // Gapped strobes at 1/4 duty
        frm = base_frm;
        send_frame(1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            build_rand();
            send_frame(int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
            repeat ($urandom_range(2, 0)) cyc();
        end

        repeat (6) cyc();
        @(negedge clk_ir);
        chk("hdr_left",      144'(exp_hdr.size()), 0);
        chk("pld_left",      144'(exp_pld.size()), 0);
        chk("err_left",      144'(exp_err.size()), 0);
        chk("err_code_held", 144'(err_code_od), 144'(last_err));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
